fp_dot_pipe: RTL and testbench
==============================

Name: fp_dot_pipe

Overview:
- Parametrised, fully pipelined floating-point dot-product engine: out = sum over i of a[i]*b[i], for N_LANES lanes.
- Built from N_LANES fpu_mul instances feeding a balanced fpu_add reduction tree.
- Delay registers are inserted automatically for unpaired tree operands.
- Adds a valid/tag sideband pipeline and an in-flight tracker. Sits between operand-fetch logic and a result writer in matrix-multiply datapaths.

Parameters:
- BITS, 32: operand/result width (IEEE single at default).
- N_LANES, 4: number of product terms; legal 1..16.
- TAG_W, 8: width of the user tag carried alongside each vector.
- MUL_LAT, 5: clock latency of fpu_mul; must match the instantiated core.
- ADD_LAT, 6: clock latency of fpu_add; must match the instantiated core.

Ports:
- clock, in, 1: sole clock, rising edge.
- reset, in, 1: synchronous, active-high reset.
- in_valid, in, 1: a/b/in_tag valid this cycle.
- a, in, N_LANES*BITS: lane i at bits [i*BITS +: BITS].
- b, in, N_LANES*BITS: same packing as a.
- in_tag, in, TAG_W: user tag, returned with the result.
- out_valid, out, 1: out/out_tag valid this cycle.
- out, out, BITS: dot-product result.
- out_tag, out, TAG_W: tag of the vector producing out.
- in_flight, out, $clog2(LAT+2): number of accepted vectors not yet output.
- busy, out, 1: in_flight != 0.

Behaviour:
- LEVELS = ceil(log2(N_LANES)), with LEVELS = 0 for N_LANES = 1. LAT = MUL_LAT + LEVELS*ADD_LAT.
- No backpressure. One vector is accepted per cycle whenever in_valid=1. Back-to-back input is sustained indefinitely.
- out_valid is asserted exactly LAT cycles after the in_valid cycle, with that vector's result and tag.
- Tree level k pairs adjacent operands (0+1, 2+3, ...). An odd trailing operand passes through an ADD_LAT-deep register delay so it aligns with its level peers.
- For N_LANES = 1, out is the product directly.
- Summation order is fixed as above, so results are bit-exact and reproducible.
- The valid pipe is a LAT-deep shift register of in_valid. The tag pipe is a LAT-deep shift register of in_tag.
- out and out_tag are forced to 0 whenever out_valid=0. Datapath contents are never exposed unqualified.
- in_flight counter:
  - +1 on in_valid alone.
  - -1 on out_valid alone.
  - Unchanged when both assert in the same cycle.
  - Never exceeds LAT, never underflows.
- Reset (synchronous, any cycle, including mid-stream):
  - clears the valid pipe, tag pipe and in_flight;
  - next cycle: out_valid=0, out=0, out_tag=0, in_flight=0, busy=0.
- Vectors accepted before or during reset never produce out_valid. FP core pipelines are not reset; their stale data is masked by the cleared valid pipe.
- in_valid asserted in the reset cycle is ignored. Input is accepted from the first cycle with reset=0.
- Exceptions and rounding are as produced by fpu_mul/fpu_add (round-to-nearest). The core control outputs are left unconnected.
- Elaboration fails (via $error in a generate check) if N_LANES < 1 or N_LANES > 16.

Test Plan:
- Single vector, defaults (LAT=17): a={1.0,2.0,3.0,4.0} (0x3F800000, 0x40000000, 0x40400000, 0x40800000), b=all 1.0 (0x3F800000), tag=0x5A.
  - Expected: exactly one out_valid, 17 cycles after input, out=0x41200000 (10.0), out_tag=0x5A.
  - Expected: in_flight=1 during cycles 1..17, then 0.
- N_LANES=3: a={1.0,2.0,3.0}, b={2.0,2.0,2.0}.
  - Expected: out=0x41400000 (12.0) at LAT=17. Checks the odd-operand balancing delay.
- N_LANES=1: a=3.0 (0x40400000), b=-2.0 (0xC0000000).
  - Expected: out=0xC0C00000 (-6.0) at LAT=5.
- 40 back-to-back vectors with tags 0..39 and random finite operands.
  - Expected: 40 consecutive out_valid cycles, tags in order, results matching a reference model bit-exactly.
  - Expected: in_flight saturates at 17 and busy deasserts one cycle after the last out_valid.
- Reset asserted for 1 cycle at cycle 8 of a 20-vector burst, inputs continuing afterwards.
  - Expected: no out_valid for any vector accepted at cycles 0..8.
  - Expected: the first out_valid arrives 17 cycles after the first post-reset vector.
  - Expected: in_flight=0 in the cycle after reset.
- Idle input with garbage on a/b and in_valid=0 for 50 cycles.
  - Expected: out_valid, out and out_tag remain 0 throughout, and busy=0.

Source files
------------

// File: rtl/fp_dot_pipe.sv
// Pipelined IEEE-single dot product: per-lane fpu_mul feeding a balanced fpu_add
// tree, with a valid/tag sideband pipe and an in-flight counter.
`timescale 1ns/1ps

// Fixed-depth register delay; used for core latency and odd-operand alignment.
module pipe_delay #(
  parameter int W     = 32,
  parameter int DEPTH = 1
) (
  input  logic         clock,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  generate
    if (DEPTH < 1) begin : g_bad_depth
      $error("pipe_delay: DEPTH must be at least 1");
    end
  endgenerate

  logic [W-1:0] stage_reg [DEPTH];

  always_ff @(posedge clock) begin
    stage_reg[0] <= d;
    for (int i = 1; i < DEPTH; i++) stage_reg[i] <= stage_reg[i-1];
  end

  assign q = stage_reg[DEPTH-1];
endmodule

// Single-precision multiplier, round-to-nearest-even, subnormals flushed to zero.
module fpu_mul #(
  parameter int LAT = 5
) (
  input  logic        clock,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic               sign, guard, sticky, rnd;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [47:0]        prod;
  logic [23:0]        mant;
  logic [24:0]        mant_r;
  logic [22:0]        frac;
  logic signed [10:0] exp_raw, exp_fin;
  logic [31:0]        res;

  always_comb begin
    sign   = a[31] ^ b[31];
    a_zero = (a[30:23] == 8'd0);
    b_zero = (b[30:23] == 8'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    prod   = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    // Product of two [1,2) mantissas lies in [1,4): at most one normalising shift.
    if (prod[47]) begin
      mant   = prod[47:24];
      guard  = prod[23];
      sticky = |prod[22:0];
    end else begin
      mant   = prod[46:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end
    exp_raw = $signed({3'b000, a[30:23]}) + $signed({3'b000, b[30:23]})
              - 11'sd127 + $signed({10'd0, prod[47]});
    rnd     = guard & (sticky | mant[0]);
    mant_r  = {1'b0, mant} + {24'd0, rnd};
    exp_fin = exp_raw + $signed({10'd0, mant_r[24]});
    frac    = mant_r[24] ? mant_r[23:1] : mant_r[22:0];

    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) res = 32'h7FC0_0000;
    else if (a_inf || b_inf)                                     res = {sign, 8'hFF, 23'd0};
    else if (a_zero || b_zero)                                   res = {sign, 31'd0};
    else if (exp_fin >= 11'sd255)                                res = {sign, 8'hFF, 23'd0};
    else if (exp_fin <= 11'sd0)                                  res = {sign, 31'd0};
    else                                                         res = {sign, exp_fin[7:0], frac};
  end

  pipe_delay #(.W(32), .DEPTH(LAT)) u_lat (.clock(clock), .d(res), .q(y));
endmodule

// Single-precision adder, round-to-nearest-even, subnormals flushed to zero.
module fpu_add #(
  parameter int LAT = 6
) (
  input  logic        clock,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;
  logic               guard, sticky, rnd;
  logic [31:0]        x, yv, res;
  logic [7:0]         d;
  logic [49:0]        x_w, y_w, y_lost, y_al;
  logic [50:0]        sum, norm;
  logic [5:0]         msb;
  logic [23:0]        mant;
  logic [24:0]        mant_r;
  logic [22:0]        frac;
  logic signed [10:0] exp_raw, exp_fin;

  always_comb begin
    a_zero = (a[30:23] == 8'd0);
    b_zero = (b[30:23] == 8'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    swap   = b[30:0] > a[30:0];
    x      = swap ? b : a;
    yv     = swap ? a : b;
    d      = x[30:23] - yv[30:23];
    x_w    = {1'b1, x[22:0], 26'd0};
    y_w    = {1'b1, yv[22:0], 26'd0};
    // Bits shifted past the window are jammed into the LSB as a sticky bit.
    y_lost = '0;
    y_al   = 50'd1;
    if (d < 8'd50) begin
      y_lost = y_w << (6'd50 - d[5:0]);
      y_al   = (y_w >> d[5:0]) | {49'd0, |y_lost};
    end
    if (x[31] == yv[31]) sum = {1'b0, x_w} + {1'b0, y_al};
    else                 sum = {1'b0, x_w} - {1'b0, y_al};

    msb = '0;
    for (int i = 0; i < 51; i++) if (sum[i]) msb = 6'(i);
    norm    = sum << (6'd50 - msb);
    mant    = norm[50:27];
    guard   = norm[26];
    sticky  = |norm[25:0];
    exp_raw = $signed({3'b000, x[30:23]}) + $signed({5'd0, msb}) - 11'sd49;
    rnd     = guard & (sticky | mant[0]);
    mant_r  = {1'b0, mant} + {24'd0, rnd};
    exp_fin = exp_raw + $signed({10'd0, mant_r[24]});
    frac    = mant_r[24] ? mant_r[23:1] : mant_r[22:0];

    if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) res = 32'h7FC0_0000;
    else if (a_inf)                res = {a[31], 8'hFF, 23'd0};
    else if (b_inf)                res = {b[31], 8'hFF, 23'd0};
    else if (a_zero && b_zero)     res = {a[31] & b[31], 31'd0};
    else if (a_zero)               res = b;
    else if (b_zero)               res = a;
    else if (sum == 51'd0)         res = 32'd0;
    else if (exp_fin >= 11'sd255)  res = {x[31], 8'hFF, 23'd0};
    else if (exp_fin <= 11'sd0)    res = {x[31], 31'd0};
    else                           res = {x[31], exp_fin[7:0], frac};
  end

  pipe_delay #(.W(32), .DEPTH(LAT)) u_lat (.clock(clock), .d(res), .q(y));
endmodule

module fp_dot_pipe #(
  parameter int BITS    = 32,
  parameter int N_LANES = 4,
  parameter int TAG_W   = 8,
  parameter int MUL_LAT = 5,
  parameter int ADD_LAT = 6,
  localparam int LEVELS = (N_LANES > 1) ? $clog2(N_LANES) : 0,
  localparam int LAT    = MUL_LAT + LEVELS * ADD_LAT,
  localparam int CNT_W  = $clog2(LAT + 2)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [N_LANES*BITS-1:0] a,
  input  logic [N_LANES*BITS-1:0] b,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  output logic [BITS-1:0]         out,
  output logic [TAG_W-1:0]        out_tag,
  output logic [CNT_W-1:0]        in_flight,
  output logic                    busy
);
  generate
    if (N_LANES < 1 || N_LANES > 16) begin : g_bad_lanes
      $error("fp_dot_pipe: N_LANES must be in 1..16");
    end
    if (BITS != 32) begin : g_bad_bits
      $error("fp_dot_pipe: cores are single precision, BITS must be 32");
    end
  endgenerate

  // Number of live operands at tree level k.
  function automatic int lvl_cnt(input int k);
    return (N_LANES + (1 << k) - 1) >> k;
  endfunction

  logic [BITS-1:0]  node [LEVELS+1][N_LANES];
  logic [LAT-1:0]   valid_reg;
  logic [TAG_W-1:0] tag_reg [LAT];
  logic [CNT_W-1:0] in_flight_reg, in_flight_next;

  genvar gi, gk;
  generate
    for (gi = 0; gi < N_LANES; gi++) begin : g_mul
      fpu_mul #(.LAT(MUL_LAT)) u_mul (
        .clock (clock),
        .a     (a[gi*BITS +: BITS]),
        .b     (b[gi*BITS +: BITS]),
        .y     (node[0][gi])
      );
    end
    for (gk = 1; gk <= LEVELS; gk++) begin : g_lvl
      for (gi = 0; gi < N_LANES; gi++) begin : g_node
        if (gi < lvl_cnt(gk) && 2*gi+1 < lvl_cnt(gk-1)) begin : g_add
          fpu_add #(.LAT(ADD_LAT)) u_add (
            .clock (clock),
            .a     (node[gk-1][2*gi]),
            .b     (node[gk-1][2*gi+1]),
            .y     (node[gk][gi])
          );
        end else if (gi < lvl_cnt(gk)) begin : g_pass
          // Unpaired trailing operand waits one adder latency to stay aligned.
          pipe_delay #(.W(BITS), .DEPTH(ADD_LAT)) u_dly (
            .clock (clock),
            .d     (node[gk-1][2*gi]),
            .q     (node[gk][gi])
          );
        end else begin : g_unused
          assign node[gk][gi] = '0;
        end
      end
    end
  endgenerate

  // Sideband pipes are reset; the FP cores are not, their stale data is masked.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_reg     <= '0;
      in_flight_reg <= '0;
      for (int i = 0; i < LAT; i++) tag_reg[i] <= '0;
    end else begin
      valid_reg[0]  <= in_valid;
      tag_reg[0]    <= in_tag;
      for (int i = 1; i < LAT; i++) begin
        valid_reg[i] <= valid_reg[i-1];
        tag_reg[i]   <= tag_reg[i-1];
      end
      in_flight_reg <= in_flight_next;
    end
  end

  always_comb begin
    in_flight_next = in_flight_reg;
    if (in_valid && !out_valid && in_flight_reg < CNT_W'(LAT))
      in_flight_next = in_flight_reg + CNT_W'(1);
    else if (!in_valid && out_valid && in_flight_reg != '0)
      in_flight_next = in_flight_reg - CNT_W'(1);
  end

  assign out_valid = valid_reg[LAT-1];
  assign out       = out_valid ? node[LEVELS][0] : '0;
  assign out_tag   = out_valid ? tag_reg[LAT-1] : '0;
  assign in_flight = in_flight_reg;
  assign busy      = (in_flight_reg != '0);
endmodule

// File: tb/tb_fp_dot_pipe.sv
// Scoreboard bench for fp_dot_pipe: default 4-lane instance plus 3-lane and 1-lane
// instances; expected results come from constants or a real-arithmetic model.
`timescale 1ns/1ps

module tb_fp_dot_pipe;
  localparam int LAT4 = 17;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset = 1'b1;

  logic         in_valid4 = 1'b0;
  logic [127:0] a4 = '0, b4 = '0;
  logic [7:0]   tag4 = '0;
  logic         out_valid4, busy4;
  logic [31:0]  out4;
  logic [7:0]   out_tag4;
  logic [4:0]   in_flight4;

  logic         in_valid3 = 1'b0;
  logic [95:0]  a3 = '0, b3 = '0;
  logic [7:0]   tag3 = '0;
  logic         out_valid3, busy3;
  logic [31:0]  out3;
  logic [7:0]   out_tag3;
  logic [4:0]   in_flight3;

  logic         in_valid1 = 1'b0;
  logic [31:0]  a1 = '0, b1 = '0;
  logic [7:0]   tag1 = '0;
  logic         out_valid1, busy1;
  logic [31:0]  out1;
  logic [7:0]   out_tag1;
  logic [2:0]   in_flight1;

  fp_dot_pipe dut4 (
    .clock(clock), .reset(reset), .in_valid(in_valid4), .a(a4), .b(b4), .in_tag(tag4),
    .out_valid(out_valid4), .out(out4), .out_tag(out_tag4), .in_flight(in_flight4), .busy(busy4)
  );
  fp_dot_pipe #(.N_LANES(3)) dut3 (
    .clock(clock), .reset(reset), .in_valid(in_valid3), .a(a3), .b(b3), .in_tag(tag3),
    .out_valid(out_valid3), .out(out3), .out_tag(out_tag3), .in_flight(in_flight3), .busy(busy3)
  );
  fp_dot_pipe #(.N_LANES(1)) dut1 (
    .clock(clock), .reset(reset), .in_valid(in_valid1), .a(a1), .b(b1), .in_tag(tag1),
    .out_valid(out_valid1), .out(out1), .out_tag(out_tag1), .in_flight(in_flight1), .busy(busy1)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int max_if = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [7:0]  tag;
    logic [31:0] val;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h (cycle %0d)", name, obs, expv, cyc);
    end
  endtask

  // Reference: single->double is exact, the double product of two singles is exact,
  // and sums stay exact for the operand ranges used, so one rounding per operation.
  function automatic real sp2real(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:23] == 8'd0) return 0.0;
    d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real2sp(input real r);
    logic [63:0] d;
    logic [24:0] m;
    logic        g, s;
    int          e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = int'(d[62:52]) - 896;
    m = {2'b01, d[51:29]};
    g = d[28];
    s = |d[27:0];
    if (g && (s || m[0])) m = m + 25'd1;
    if (m[24]) begin
      e++;
      m = m >> 1;
    end
    return {d[63], 8'(e), m[22:0]};
  endfunction

  function automatic logic [31:0] mul_ref(input logic [31:0] x, input logic [31:0] y);
    return real2sp(sp2real(x) * sp2real(y));
  endfunction

  function automatic logic [31:0] add_ref(input logic [31:0] x, input logic [31:0] y);
    return real2sp(sp2real(x) + sp2real(y));
  endfunction

  function automatic logic [31:0] dot4_ref(input logic [127:0] av, input logic [127:0] bv);
    logic [31:0] p [4];
    for (int i = 0; i < 4; i++) p[i] = mul_ref(av[i*32 +: 32], bv[i*32 +: 32]);
    return add_ref(add_ref(p[0], p[1]), add_ref(p[2], p[3]));
  endfunction

  function automatic logic [127:0] rand_vec();
    logic [127:0] v;
    for (int i = 0; i < 4; i++) v[i*32 +: 32] = {1'b0, 8'($urandom_range(130, 124)), 23'($urandom)};
    return v;
  endfunction

  // One cycle of stimulus on the 4-lane instance; accepted vectors go to the scoreboard.
  task automatic drive4(input logic rst, input logic v, input logic [127:0] av,
                        input logic [127:0] bv, input logic [7:0] t, input logic [31:0] expv);
    @(posedge clock);
    #1;
    reset     = rst;
    in_valid4 = v;
    a4        = av;
    b4        = bv;
    tag4      = t;
    if (rst) sb.delete();
    else if (v) sb.push_back('{t, expv, cyc + LAT4});
  endtask

  always @(negedge clock) begin
    int   exp_if;
    exp_t e;
    if (mon_en) begin
      exp_if = sb.size() - ((in_valid4 && !reset) ? 1 : 0);
      if (!reset) begin
        chk("in_flight", 32'(in_flight4), 32'(exp_if));
        chk("busy", 32'(busy4), 32'(exp_if != 0));
      end
      if (int'(in_flight4) > max_if) max_if = int'(in_flight4);
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        chk("out_valid", 32'(out_valid4), 32'd1);
        chk("out", out4, e.val);
        chk("out_tag", 32'(out_tag4), 32'(e.tag));
        $display("out tag=%h value=%h expected=%h cycle=%0d", out_tag4, out4, e.val, cyc);
      end else begin
        chk("no_out_valid", 32'(out_valid4), 32'd0);
        chk("out_masked", out4, 32'd0);
        chk("tag_masked", 32'(out_tag4), 32'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] av, bv;
    int n3, n1, at3, at1, t0;
    logic [31:0] v3, v1;
    logic [7:0]  tg3, tg1;

    repeat (3) drive4(1'b1, 1'b0, '0, '0, '0, '0);
    drive4(1'b0, 1'b0, '0, '0, '0, '0);
    mon_en = 1'b1;
    @(negedge clock);
    chk("reset_out_valid3", 32'(out_valid3), 32'd0);
    chk("reset_in_flight3", 32'(in_flight3), 32'd0);
    chk("reset_busy1", 32'(busy1), 32'd0);

    // {1,2,3,4} . {1,1,1,1} = 10.0
    drive4(1'b0, 1'b1, {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000},
           {4{32'h3F800000}}, 8'h5A, 32'h41200000);
    repeat (20) drive4(1'b0, 1'b0, '0, '0, '0, '0);

    // Mixed signs: {3,-1,0.5,-0.25} . {2,2,2,2} = (6-2)+(1-0.5) = 4.5
    drive4(1'b0, 1'b1, {32'hBE800000, 32'h3F000000, 32'hBF800000, 32'h40400000},
           {4{32'h40000000}}, 8'h11, 32'h40900000);
    repeat (20) drive4(1'b0, 1'b0, '0, '0, '0, '0);

    max_if = 0;
    for (int i = 0; i < 40; i++) begin
      av = rand_vec();
      bv = rand_vec();
      drive4(1'b0, 1'b1, av, bv, 8'(i), dot4_ref(av, bv));
    end
    repeat (20) drive4(1'b0, 1'b0, '0, '0, '0, '0);
    chk("in_flight_max", 32'(max_if), 32'd17);
    chk("burst_drained", 32'(sb.size()), 32'd0);

    // Burst with a one-cycle reset at vector 8; earlier vectors must vanish.
    for (int i = 0; i < 20; i++) begin
      av = rand_vec();
      bv = rand_vec();
      drive4(i == 8, 1'b1, av, bv, 8'(8'h80 + i), dot4_ref(av, bv));
      if (i == 9) begin
        @(negedge clock);
        chk("in_flight_after_reset", 32'(in_flight4), 32'd0);
      end
    end
    repeat (25) drive4(1'b0, 1'b0, '0, '0, '0, '0);
    chk("reset_burst_drained", 32'(sb.size()), 32'd0);

    // Garbage operands with in_valid low must never surface.
    repeat (50) drive4(1'b0, 1'b0, {$urandom, $urandom, $urandom, $urandom},
                       {$urandom, $urandom, $urandom, $urandom}, 8'($urandom), '0);
    chk("idle_busy", 32'(busy4), 32'd0);

    // 3-lane {1,2,3}.{2,2,2}=12.0 and 1-lane 3.0*-2.0=-6.0, launched together.
    @(posedge clock);
    #1;
    in_valid3 = 1'b1; a3 = {32'h40400000, 32'h40000000, 32'h3F800000}; b3 = {3{32'h40000000}}; tag3 = 8'h33;
    in_valid1 = 1'b1; a1 = 32'h40400000; b1 = 32'hC0000000; tag1 = 8'h01;
    t0 = cyc;
    @(posedge clock);
    #1;
    in_valid3 = 1'b0;
    in_valid1 = 1'b0;
    n3 = 0; n1 = 0; at3 = 0; at1 = 0; v3 = '0; v1 = '0; tg3 = '0; tg1 = '0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clock);
      if (c == 0) chk("dut3_in_flight", 32'(in_flight3), 32'd1);
      if (out_valid3) begin n3++; at3 = cyc; v3 = out3; tg3 = out_tag3; end
      if (out_valid1) begin n1++; at1 = cyc; v1 = out1; tg1 = out_tag1; end
    end
    $display("dut3 value=%h tag=%h latency=%0d", v3, tg3, at3 - t0);
    $display("dut1 value=%h tag=%h latency=%0d", v1, tg1, at1 - t0);
    chk("dut3_count", 32'(n3), 32'd1);
    chk("dut3_latency", 32'(at3 - t0), 32'd17);
    chk("dut3_out", v3, 32'h41400000);
    chk("dut3_tag", 32'(tg3), 32'h33);
    chk("dut1_count", 32'(n1), 32'd1);
    chk("dut1_latency", 32'(at1 - t0), 32'd5);
    chk("dut1_out", v1, 32'hC0C00000);
    chk("dut1_tag", 32'(tg1), 32'h01);
    chk("dut1_idle_busy", 32'(busy1), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
